// File: rtl/spi_mem_bridge.sv
// SPI-mode-0 slave that bulk-loads and reads back a byte memory (write 0x02, read 0x03).
// Optional status command 0x05 and its sticky flags are built with SPI_MEM_BRIDGE_STATUS_EN.
module spi_mem_bridge #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int BC_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] CMD_WR = DATA_W'(8'h02);
  localparam logic [DATA_W-1:0] CMD_RD = DATA_W'(8'h03);
`ifdef SPI_MEM_BRIDGE_STATUS_EN
  localparam logic [DATA_W-1:0] CMD_ST = DATA_W'(8'h05);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_WR_DATA, S_RD_DATA, S_DISCARD
`ifdef SPI_MEM_BRIDGE_STATUS_EN
    , S_RD_STATUS
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  state_t                 state_q, state_d;
  logic                   write_mode_q, write_mode_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic                   mem_we_q, mem_we_d;
  logic [READ_LATENCY:0]  ld_pipe_q, ld_pipe_d;

  logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, byte_done;
  logic [DATA_W-1:0] rx_byte;
  logic [ADDR_W-1:0] addr_inc;

`ifdef SPI_MEM_BRIDGE_STATUS_EN
  logic bad_cmd_q, bad_cmd_d, wrapped_q, wrapped_d;
  logic bad_evt, rd_inc, status_ld;
  logic [DATA_W-1:0] status_byte;
  assign status_byte = {bad_cmd_q, wrapped_q, {(DATA_W-3){1'b0}}, mem_addr_q[ADDR_W-1]};
`endif

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign byte_done = sck_rise && (bit_cnt_q == BC_W'(DATA_W-1));
  assign rx_byte   = {rx_shift_q[DATA_W-2:0], mosi_s};
  assign addr_inc  = mem_addr_q + ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    write_mode_d = write_mode_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    ld_pipe_d    = {ld_pipe_q[READ_LATENCY-1:0], 1'b0};
`ifdef SPI_MEM_BRIDGE_STATUS_EN
    bad_evt   = 1'b0;
    rd_inc    = 1'b0;
    status_ld = 1'b0;
`endif
    // The address advances the cycle after a write strobe, so the write uses the old address.
    if (mem_we_q) mem_addr_d = addr_inc;
    if (cs_s) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      ld_pipe_d  = '0;
    end else if (state_q == S_IDLE) begin
      state_d    = S_CMD;
      tx_shift_d = '0;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end else begin
      if (sck_rise) begin
        rx_shift_d = rx_byte;
        bit_cnt_d  = byte_done ? '0 : bit_cnt_q + BC_W'(1);
      end else if (sck_fall && bit_cnt_q != '0) begin
        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
      end
      if (ld_pipe_q[READ_LATENCY]) tx_shift_d = mem_rdata;
      if (byte_done) begin
        case (state_q)
          S_CMD: begin
            if (rx_byte == CMD_WR) begin
              state_d      = S_ADDR_HI;
              write_mode_d = 1'b1;
            end else if (rx_byte == CMD_RD) begin
              state_d      = S_ADDR_HI;
              write_mode_d = 1'b0;
`ifdef SPI_MEM_BRIDGE_STATUS_EN
            end else if (rx_byte == CMD_ST) begin
              state_d    = S_RD_STATUS;
              tx_shift_d = status_byte;
              status_ld  = 1'b1;
`endif
            end else begin
              state_d    = S_DISCARD;
              tx_shift_d = '0;
`ifdef SPI_MEM_BRIDGE_STATUS_EN
              bad_evt = 1'b1;
`endif
            end
          end
          S_ADDR_HI: begin
            mem_addr_d[ADDR_W-1:DATA_W] = rx_byte[ADDR_W-DATA_W-1:0];
            state_d = S_ADDR_LO;
          end
          S_ADDR_LO: begin
            mem_addr_d[DATA_W-1:0] = rx_byte;
            if (write_mode_q) begin
              state_d = S_WR_DATA;
            end else begin
              state_d      = S_RD_DATA;
              ld_pipe_d[0] = 1'b1;
            end
          end
          S_WR_DATA: begin
            mem_wdata_d = rx_byte;
            mem_we_d    = 1'b1;
          end
          S_RD_DATA: begin
            mem_addr_d   = addr_inc;
            ld_pipe_d[0] = 1'b1;
`ifdef SPI_MEM_BRIDGE_STATUS_EN
            rd_inc = 1'b1;
          end
          S_RD_STATUS: begin
            tx_shift_d = status_byte;
            status_ld  = 1'b1;
`endif
          end
          default: tx_shift_d = '0;
        endcase
      end
    end
`ifdef SPI_MEM_BRIDGE_STATUS_EN
    // A flag-setting event in the same cycle as the status load survives the clear.
    bad_cmd_d = (bad_cmd_q & ~status_ld) | bad_evt;
    wrapped_d = (wrapped_q & ~status_ld) | ((mem_we_q | rd_inc) & (&mem_addr_q));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sck_prev_q   <= 1'b0;
      state_q      <= S_IDLE;
      write_mode_q <= 1'b0;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      ld_pipe_q    <= '0;
`ifdef SPI_MEM_BRIDGE_STATUS_EN
      bad_cmd_q    <= 1'b0;
      wrapped_q    <= 1'b0;
`endif
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q   <= sck_s;
      state_q      <= state_d;
      write_mode_q <= write_mode_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      ld_pipe_q    <= ld_pipe_d;
`ifdef SPI_MEM_BRIDGE_STATUS_EN
      bad_cmd_q    <= bad_cmd_d;
      wrapped_q    <= wrapped_d;
`endif
    end
  end

  assign spi_miso  = tx_shift_q[DATA_W-1];
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = ~cs_s;
endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: SPI host tasks, a registered 512x8 memory model,
// and expected queues for memory writes and MISO bytes.
module tb_spi_mem_bridge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int sck_half = 8;

  logic [16:0] exp_q[$];    // expected writes {addr, data}
  logic [7:0]  rd_q[$];     // expected MISO bytes
  logic [7:0]  mem [512];
  logic [7:0]  model_mem [512];
  logic [8:0]  model_addr = 9'h000;

  spi_mem_bridge dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_we observed=%h@%h expected=no write", mem_wdata, mem_addr);
      end else begin
        e = exp_q.pop_front();
        assert ({mem_addr, mem_wdata} === e) else begin
          failures++;
          $error("FAIL mem_write observed=%h expected=%h", {mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (sck_half) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (sck_half) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input bit chk, input logic [7:0] exp);
    logic [7:0] rx;
    logic [7:0] want;
    if (chk) rd_q.push_back(exp);
    spi_bits(tx, 8, rx);
    if (chk) begin
      want = rd_q.pop_front();
      checks++;
      assert (rx === want) else begin
        failures++;
        $error("FAIL miso_byte observed=%h expected=%h", rx, want);
      end
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic start_cmd(input logic [7:0] cmd, input logic [8:0] addr);
    cs_low();
    xfer(cmd, 1'b0, 8'h00);
    xfer({7'b0, addr[8]}, 1'b0, 8'h00);
    xfer(addr[7:0], 1'b0, 8'h00);
    model_addr = addr;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    exp_q.push_back({model_addr, d});
    model_mem[model_addr] = d;
    model_addr = model_addr + 9'd1;
    xfer(d, 1'b0, 8'h00);
  endtask

  task automatic rd_byte();
    logic [7:0] e;
    e = model_mem[model_addr];
    model_addr = model_addr + 9'd1;
    xfer(8'h00, 1'b1, e);
  endtask

  initial begin
    logic [7:0] rx;
    // Power-on reset
    repeat (5) @(negedge clk);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_wdata", 32'(mem_wdata), 32'h0);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in the middle of ADDR_LO
    cs_low();
    check("busy_cs_low", 32'(busy), 32'h1);
    xfer(8'h02, 1'b0, 8'h00);
    xfer(8'h01, 1'b0, 8'h00);
    spi_bits(8'h10, 3, rx);
    check("addr_hi_set", 32'(mem_addr), 32'h100);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", 32'(mem_addr), 32'h0);
    check("midrst_we", 32'(mem_we), 32'h0);
    check("midrst_wdata", 32'(mem_wdata), 32'h0);
    check("midrst_miso", 32'(spi_miso), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write burst
    start_cmd(8'h02, 9'h110);
    wr_byte(8'hA5);
    wr_byte(8'h5A);
    cs_high();
    check("wr_final_addr", 32'(mem_addr), 32'h112);
    check("wr_busy_idle", 32'(busy), 32'h0);

    // Abort during the first data byte, then a clean frame
    start_cmd(8'h02, 9'h020);
    spi_bits(8'hC3, 4, rx);
    cs_high();
    check("abort_addr", 32'(mem_addr), 32'h020);
    start_cmd(8'h02, 9'h021);
    wr_byte(8'h77);
    cs_high();
    check("after_abort_addr", 32'(mem_addr), 32'h022);

    // Unknown command: MISO stays low, nothing written
    cs_low();
    xfer(8'hFF, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) xfer(8'($urandom_range(0, 255)), 1'b1, 8'h00);
    cs_high();
    check("unknown_addr", 32'(mem_addr), 32'h022);
`ifdef SPI_MEM_BRIDGE_STATUS_EN
    cs_low();
    xfer(8'h05, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'h80);
    xfer(8'h00, 1'b1, 8'h00);
    cs_high();
`endif

    // Preload across the top of memory (write wraps to 0), then read back with wrap
    start_cmd(8'h02, 9'h1FE);
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    cs_high();
    check("wr_wrap_addr", 32'(mem_addr), 32'h001);
    start_cmd(8'h03, 9'h1FE);
    for (int i = 0; i < 3; i++) rd_byte();
    cs_high();
    check("rd_wrap_addr", 32'(mem_addr), 32'h001);

    // Sequential read at the fastest SCK (clk/8)
    start_cmd(8'h02, 9'h040);
    for (int i = 0; i < 8; i++) wr_byte(8'($urandom_range(0, 255)));
    cs_high();
    sck_half = 4;
    start_cmd(8'h03, 9'h040);
    for (int i = 0; i < 8; i++) rd_byte();
    cs_high();
    check("fast_rd_addr", 32'(mem_addr), 32'h048);

    repeat (10) @(negedge clk);
    check("wr_queue_empty", 32'(exp_q.size()), 32'h0);
    check("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_mem_bridge.md
Name: spi_mem_bridge

Overview:
SPI-slave front end that sits directly upstream of the 512x8 byte memory and drives its address, write-data and write-enable.
An external host uses it to bulk-load and read back memory contents over four pins, instead of driving the address and data pins byte by byte.
- Protocol: command byte, two address bytes, then a data stream with address auto-increment.
- All SPI inputs are oversampled by the system clock; SPI mode 0, MSB first.

Parameters:
ADDR_W, 9, memory address width (depth 2^ADDR_W)
DATA_W, 8, memory data width; also the SPI byte width
SYNC_STAGES, 2, synchroniser flops on spi_sck, spi_cs_n and spi_mosi (minimum 2)
READ_LATENCY, 1, clk cycles from mem_addr change to valid mem_rdata

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
spi_sck  in  1  SPI clock, async; frequency must be <= clk/8
spi_cs_n  in  1  SPI chip select, active low, async
spi_mosi  in  1  SPI data in, async
spi_miso  out  1  SPI data out; always driven, no tristate
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe, one clk per byte
mem_rdata  in  DATA_W  memory read data, registered in the memory
busy  out  1  high while CS is asserted (synchronised)

Behaviour:
- Reset: all outputs 0, state IDLE, shift registers 0, bit counter 0. Reset is async assert; deassertion is synchronised externally.
- Sampling: inputs pass through SYNC_STAGES flops, then 1-clk edge detect on the synchronised SCK.
  - Rising edge: shift MOSI into rx_shift LSB, bit_cnt += 1 mod 8.
  - Falling edge with bit_cnt != 0: shift tx_shift left.
  - spi_miso = tx_shift[7] at all times.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA, DISCARD.
  - Synchronised CS high -> IDLE from any state, same cycle it is seen.
  - On that abort: bit_cnt = 0, the partial byte is dropped, no write is issued, mem_addr is held.
- IDLE -> CMD when synchronised CS falls; tx_shift = 0.
- CMD, byte complete:
  - 0x02 -> ADDR_HI, write mode.
  - 0x03 -> ADDR_HI, read mode.
  - Any other value -> DISCARD.
- DISCARD: MISO = 0 and bytes are ignored until CS rises.
- ADDR_HI complete: mem_addr[8] = rx[0]; rx[7:1] are ignored.
- ADDR_LO complete: mem_addr[7:0] = rx.
  - Write mode -> WR_DATA.
  - Read mode -> RD_DATA; tx_shift is loaded with mem_rdata READ_LATENCY clks after the address update. This always completes before the next SCK rising edge, given SCK <= clk/8.
- WR_DATA, byte complete:
  - Cycle N: mem_wdata = rx, mem_we = 1 for exactly one clk, at the current mem_addr.
  - Cycle N+1: mem_addr += 1.
- RD_DATA, byte complete (8th rising edge): mem_addr += 1, then tx_shift reloads after READ_LATENCY. The first falling edge after the byte does not shift (bit_cnt == 0).
- Address wrap: 511 + 1 -> 0, silently, in both modes.
- CS deasserted on the same clk as a byte completes: the abort wins, so no write and no increment.
- busy follows synchronised CS low.

Optional Feature:
Macro: SPI_MEM_BRIDGE_STATUS_EN
- With the macro:
  - Command 0x05 -> RD_STATUS state; tx_shift = {bad_cmd, wrapped, 5'b0, mem_addr[8]}, reloaded at each byte boundary.
  - bad_cmd is sticky: set when an unknown command is received.
  - wrapped is sticky: set on a 511->0 increment.
  - Both flags clear when the status byte is loaded. A set event in that same cycle wins.
- Without the macro: 0x05 is an unknown command (-> DISCARD), and neither flag nor RD_STATUS exists.

Test Plan:
- Reset mid-frame: assert rst_n=0 during ADDR_LO -> all outputs 0, state IDLE; the next frame is decoded normally.
- Write burst: CS low, 0x02 0x01 0x10, data 0xA5 0x5A, CS high.
  - Required: two 1-clk mem_we pulses: addr 0x110 data 0xA5, then addr 0x111 data 0x5A.
  - Final mem_addr = 0x112.
- Read burst: preload mem[0x1FE]=0x11 and mem[0x1FF]=0x22, then 0x03 0x01 0xFE and 3 dummy bytes.
  - Required MISO bytes: 0x11, 0x22, then mem[0x000] (wrap).
  - mem_we stays 0 throughout.
- Abort: 0x02 0x00 0x20, 4 data bits, CS high -> no mem_we pulse, mem_addr = 0x020. Next frame 0x02 0x00 0x21 0x77 -> write 0x77 @ 0x021.
- Unknown command 0xFF followed by 3 bytes -> MISO = 0 and no mem_we.
  - With SPI_MEM_BRIDGE_STATUS_EN: a subsequent 0x05 frame returns 0x80, then 0x00 on the second status byte.
- SCK at exactly clk/8 with 0x03 read of 8 sequential bytes -> all bytes match memory and there are no shift-timing errors.
